// File: rtl/weight_store_multilane.sv
// weight_store_multilane: streamed LeNet-5 weight store with per-region done flags.
// Optional WEIGHT_CHECKSUM_EN adds a 32-bit checksum of the accepted words.
module weight_store_multilane #(
  parameter int BW = 8,
  parameter int LANES = 4,
  parameter int SIZE1 = 150,
  parameter int SIZE2 = 2400,
  parameter int SIZE3 = 400,
  localparam int TOTAL = SIZE1 + SIZE2 + SIZE3,
  localparam int CW = $clog2(TOTAL + 1)
) (
  input  logic                  clk,
  input  logic                  global_rst_n,
  input  logic                  i_clr,
  input  logic [BW*LANES-1:0]   i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [BW*SIZE1-1:0]   o_weight1,
  output logic [BW*SIZE2-1:0]   o_weight2,
  output logic [BW*SIZE3-1:0]   o_weight_fc,
  output logic [2:0]            o_done,
  output logic [CW-1:0]         o_count,
  output logic                  o_empty,
  output logic                  o_full,
`ifdef WEIGHT_CHECKSUM_EN
  input  logic [31:0]           i_chk_expected,
  output logic                  o_chk_valid,
  output logic                  o_chk_err,
`endif
  output logic                  o_overflow
);
  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0] done_q, done_d;
  logic ovf_q, ovf_d, accept;
  logic [31:0] nxt;
  logic [BW-1:0] mem_q [TOTAL];
  assign o_ready = (state_q != FULL) && !i_clr;
  assign accept = i_valid && o_ready;
  assign o_done = done_q;
  assign o_count = count_q;
  assign o_empty = state_q == IDLE;
  assign o_full = state_q == FULL;
  assign o_overflow = ovf_q;
  always_comb begin
    nxt = 32'(count_q) + 32'(LANES);
    count_d = i_clr ? '0 : accept ? (nxt >= 32'(TOTAL) ? CW'(TOTAL) : CW'(nxt)) : count_q;
    state_d = i_clr ? IDLE : (accept && nxt >= 32'(TOTAL)) ? FULL : accept ? LOAD : state_q;
    done_d = i_clr ? 3'b000 : done_q | ({3{accept}} &
             {nxt >= 32'(TOTAL), nxt >= 32'(SIZE1 + SIZE2), nxt >= 32'(SIZE1)});
    ovf_d = i_clr ? 1'b0 : ovf_q | (i_valid && state_q == FULL);
  end
  always_ff @(posedge clk or negedge global_rst_n)
    if (!global_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  // Lanes landing at or past TOTAL never match a word index, so they drop out.
  always_ff @(posedge clk or negedge global_rst_n)
    if (!global_rst_n) begin
      for (int j = 0; j < TOTAL; j++) mem_q[j] <= '0;
    end else if (accept) begin
      for (int j = 0; j < TOTAL; j++)
        for (int k = 0; k < LANES; k++)
          if (int'(count_q) + k == j) mem_q[j] <= i_data[k*BW +: BW];
    end
  for (genvar j = 0; j < SIZE1; j++) begin : g_w1
    assign o_weight1[j*BW +: BW] = mem_q[j];
  end
  for (genvar j = 0; j < SIZE2; j++) begin : g_w2
    assign o_weight2[j*BW +: BW] = mem_q[SIZE1+j];
  end
  for (genvar j = 0; j < SIZE3; j++) begin : g_w3
    assign o_weight_fc[j*BW +: BW] = mem_q[SIZE1+SIZE2+j];
  end
`ifdef WEIGHT_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic chk_seen_q, chk_seen_d, chk_valid_q, chk_valid_d, chk_err_q, chk_err_d;
  assign o_chk_valid = chk_valid_q;
  assign o_chk_err = chk_err_q;
  always_comb begin
    sum_d = i_clr ? '0 : sum_q;
    for (int k = 0; k < LANES; k++)
      if (accept && int'(count_q) + k < TOTAL) sum_d = sum_d + 32'($signed(i_data[k*BW +: BW]));
    chk_seen_d = i_clr ? 1'b0 : chk_seen_q | (state_q == FULL);
    chk_valid_d = !i_clr && state_q == FULL && !chk_seen_q;
    chk_err_d = i_clr ? 1'b0 : chk_valid_d ? (sum_q != i_chk_expected) : chk_err_q;
  end
  always_ff @(posedge clk or negedge global_rst_n)
    if (!global_rst_n) begin
      sum_q <= '0;
      chk_seen_q <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      chk_seen_q <= chk_seen_d;
      chk_valid_q <= chk_valid_d;
      chk_err_q <= chk_err_d;
    end
`endif
endmodule

// File: tb/tb_weight_store_multilane.sv
// tb_weight_store_multilane: directed vector table plus hand sequences for weight_store_multilane.
module tb_weight_store_multilane;
  localparam int BW = 8, L = 2, S1 = 4, S2 = 6, S3 = 5, T = 15, CW = 4;
  logic clk = 1'b0, global_rst_n = 1'b0, i_clr = 1'b0, i_valid = 1'b0, o_ready;
  logic [BW*L-1:0] i_data = '0;
  logic [BW*S1-1:0] o_weight1;
  logic [BW*S2-1:0] o_weight2;
  logic [BW*S3-1:0] o_weight_fc;
  logic [2:0] o_done;
  logic [CW-1:0] o_count;
  logic o_empty, o_full, o_overflow;
`ifdef WEIGHT_CHECKSUM_EN
  logic [31:0] i_chk_expected = 32'd120;
  logic o_chk_valid, o_chk_err;
`endif
  weight_store_multilane #(.BW(BW), .LANES(L), .SIZE1(S1), .SIZE2(S2), .SIZE3(S3)) dut (
    .clk(clk), .global_rst_n(global_rst_n), .i_clr(i_clr), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_weight1(o_weight1), .o_weight2(o_weight2), .o_weight_fc(o_weight_fc),
    .o_done(o_done), .o_count(o_count), .o_empty(o_empty), .o_full(o_full),
`ifdef WEIGHT_CHECKSUM_EN
    .i_chk_expected(i_chk_expected), .o_chk_valid(o_chk_valid), .o_chk_err(o_chk_err),
`endif
    .o_overflow(o_overflow));
  always #5 clk = ~clk;
  typedef struct {
    logic clr; logic valid; logic [15:0] data;
    logic ready; logic [3:0] cnt; logic [2:0] done; logic full; logic ovf; logic empty;
  } vec_t;
  vec_t v[15];
  logic [7:0] img[T];
  int n_vec = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic chk_img(input string nm);
    logic [BW*T-1:0] e;
    for (int j = 0; j < T; j++) e[j*BW +: BW] = img[j];
    chk({nm, " w1"}, 64'(o_weight1), 64'(e[31:0]));
    chk({nm, " w2"}, 64'(o_weight2), 64'(e[79:32]));
    chk({nm, " fc"}, 64'(o_weight_fc), 64'(e[119:80]));
  endtask
  task automatic chk_state(input string nm, input logic [3:0] c, input logic [2:0] d,
                           input logic f, input logic o, input logic e);
    chk({nm, " count"}, 64'(o_count), 64'(c));
    chk({nm, " done"}, 64'(o_done), 64'(d));
    chk({nm, " full"}, 64'(o_full), 64'(f));
    chk({nm, " ovf"}, 64'(o_overflow), 64'(o));
    chk({nm, " empty"}, 64'(o_empty), 64'(e));
  endtask
  task automatic load_all();
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk); i_valid = 1'b1; i_data = {8'(2*n), 8'(2*n-1)};
    end
    @(negedge clk); i_valid = 1'b0;
  endtask
  initial begin
    for (int n = 1; n <= 8; n++)
      v[n-1] = '{1'b0, 1'b1, {8'(2*n), 8'(2*n-1)}, 1'b1, (n == 8) ? 4'd15 : 4'(2*n),
                 (n >= 8) ? 3'b111 : (n >= 5) ? 3'b011 : (n >= 2) ? 3'b001 : 3'b000,
                 n == 8, 1'b0, 1'b0};
    v[8]  = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 4'd15, 3'b111, 1'b1, 1'b1, 1'b0};
    v[9]  = '{1'b0, 1'b1, 16'hAAAA, 1'b0, 4'd15, 3'b111, 1'b1, 1'b1, 1'b0};
    v[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1};
    v[11] = '{1'b0, 1'b1, 16'h2221, 1'b1, 4'd2, 3'b000, 1'b0, 1'b0, 1'b0};
    v[12] = '{1'b0, 1'b1, 16'h2423, 1'b1, 4'd4, 3'b001, 1'b0, 1'b0, 1'b0};
    v[13] = '{1'b0, 1'b1, 16'h2625, 1'b1, 4'd6, 3'b001, 1'b0, 1'b0, 1'b0};
    v[14] = '{1'b1, 1'b1, 16'h7777, 1'b0, 4'd0, 3'b000, 1'b0, 1'b0, 1'b1};
    #2;
    for (int j = 0; j < T; j++) img[j] = 8'h00;
    chk_state("reset", 4'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("reset ready", 64'(o_ready), 64'd1);
    chk_img("reset");
    @(negedge clk); global_rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      i_clr = v[i].clr; i_valid = v[i].valid; i_data = v[i].data;
      #1 chk($sformatf("v%0d ready", i), 64'(o_ready), 64'(v[i].ready));
      @(posedge clk); #1;
      chk_state($sformatf("v%0d", i), v[i].cnt, v[i].done, v[i].full, v[i].ovf, v[i].empty);
      if (i == 9) begin
        for (int j = 0; j < T; j++) img[j] = 8'(j + 1);
        chk_img("full image");
        chk("fc top", 64'(o_weight_fc[39:32]), 64'd15);
      end
    end
    for (int j = 0; j < 6; j++) img[j] = 8'(8'h21 + j);
    chk_img("clr keeps");
    @(negedge clk); i_clr = 1'b1; i_valid = 1'b0;
    @(negedge clk); i_clr = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      i_valid = 1'b1; i_data = {8'(2*n), 8'(2*n-1)};
      @(posedge clk); #1 chk($sformatf("gap beat%0d count", n), 64'(o_count), 64'((n == 8) ? 15 : 2*n));
      @(negedge clk); i_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("gap hold%0d count", n), 64'(o_count), 64'((n == 8) ? 15 : 2*n));
    end
    for (int j = 0; j < T; j++) img[j] = 8'(j + 1);
    chk_state("gapped", 4'd15, 3'b111, 1'b1, 1'b0, 1'b0);
    chk_img("gapped");
    @(negedge clk); i_clr = 1'b1;
    @(negedge clk); i_clr = 1'b0; i_valid = 1'b1; i_data = 16'h5251;
    @(negedge clk); i_data = 16'h5453;
    @(negedge clk); i_valid = 1'b0;
    chk("pre-reset count", 64'(o_count), 64'd4);
    #2 global_rst_n = 1'b0;
    #1;
    for (int j = 0; j < T; j++) img[j] = 8'h00;
    chk_state("async rst", 4'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    chk_img("async rst");
    @(negedge clk); global_rst_n = 1'b1;
`ifdef WEIGHT_CHECKSUM_EN
    i_chk_expected = 32'd120;
    load_all();
    chk("chk pre", 64'(o_chk_valid), 64'd0);
    @(posedge clk); #1;
    chk("chk pulse", 64'(o_chk_valid), 64'd1);
    chk("chk err ok", 64'(o_chk_err), 64'd0);
    @(posedge clk); #1;
    chk("chk pulse end", 64'(o_chk_valid), 64'd0);
    @(negedge clk); i_clr = 1'b1; i_chk_expected = 32'd121;
    @(negedge clk); i_clr = 1'b0;
    load_all();
    @(posedge clk); #1;
    chk("chk pulse2", 64'(o_chk_valid), 64'd1);
    chk("chk err bad", 64'(o_chk_err), 64'd1);
    @(posedge clk); #1;
    chk("chk err held", 64'(o_chk_err), 64'd1);
`else
    load_all();
    chk_state("reload", 4'd15, 3'b111, 1'b1, 1'b0, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
